// File: rtl/alu_result_sink_if.sv
// Purpose: ALU-result and writeback handshake bundle between ALU, sink and regfile port.
// Latency: none (wires only).
// Backpressure: alu_ready from the sink, wb_ready from the writeback consumer.
// Ports: alu_valid/alu_ready/alu_c/alu_flags/flag_mask (ALU side),
//        wb_valid/wb_ready/wb_data (writeback side).
`timescale 1ns/1ps
interface alu_result_sink_if #(
    parameter int WIDTH  = 16,
    parameter int NFLAGS = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [WIDTH-1:0]  alu_c;
    logic [NFLAGS-1:0] alu_flags;
    logic [NFLAGS-1:0] flag_mask;
    logic              wb_valid;
    logic              wb_ready;
    logic [WIDTH-1:0]  wb_data;

    // master: drives ALU results and the writeback ready
    modport master (
        output alu_valid, alu_c, alu_flags, flag_mask, wb_ready,
        input  alu_ready, wb_valid, wb_data
    );

    // slave: the result sink itself
    modport slave (
        input  alu_valid, alu_c, alu_flags, flag_mask, wb_ready,
        output alu_ready, wb_valid, wb_data
    );
endinterface

// File: rtl/alu_result_sink.sv
// Purpose: one-entry writeback register for ALU results, PSR update under flag mask, condition evaluation.
// Latency: 1 cycle alu_valid -> wb_valid; psr/op_count update on the accepting edge; cond_true combinational.
// Backpressure: alu_ready = !wb_valid | wb_ready; a full, stalled entry freezes wb_data and psr.
// Ports: clk, rst_n (async active-low); bus (slave modport: ALU + writeback handshake);
//        psr_wr_en/psr_wr_data (direct PSR write); psr; cond/cond_true; op_count (saturating).
`timescale 1ns/1ps
module alu_result_sink #(
    parameter int WIDTH  = 16,
    parameter int NFLAGS = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_sink_if.slave     bus,
    input  logic                 psr_wr_en,
    input  logic [NFLAGS-1:0]    psr_wr_data,
    output logic [NFLAGS-1:0]    psr,
    input  logic [3:0]           cond,
    output logic                 cond_true,
    output logic [CNT_W-1:0]     op_count
);
    // PSR bit positions
    localparam int C_BIT = 4;
    localparam int L_BIT = 3;
    localparam int F_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int N_BIT = 0;

    logic              wb_valid_q;
    logic [WIDTH-1:0]  wb_data_q;
    logic [NFLAGS-1:0] psr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc;

    // Accept whenever the entry is empty or is being drained this cycle,
    // so a continuous stream flows with no bubble.
    assign bus.alu_ready = ~wb_valid_q | bus.wb_ready;
    assign acc           = bus.alu_valid & bus.alu_ready;

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign psr           = psr_q;
    assign op_count      = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else if (acc) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= bus.alu_c;
        end else if (wb_valid_q && bus.wb_ready) begin
            // drained with nothing new: data is kept, only valid drops
            wb_valid_q <= 1'b0;
        end
    end

    // Direct write wins over the flag update of an op accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q <= '0;
        end else if (psr_wr_en) begin
            psr_q <= psr_wr_data;
        end else if (acc) begin
            psr_q <= (psr_q & ~bus.flag_mask) | (bus.alu_flags & bus.flag_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (acc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Evaluated on the registered PSR only: a branch sees the flags of the
    // previously accepted op, never the one arriving this cycle.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true =  psr_q[Z_BIT];
            4'h1: cond_true = ~psr_q[Z_BIT];
            4'h2: cond_true =  psr_q[C_BIT];
            4'h3: cond_true = ~psr_q[C_BIT];
            4'h4: cond_true =  psr_q[L_BIT];
            4'h5: cond_true = ~psr_q[L_BIT];
            4'h6: cond_true =  psr_q[N_BIT];
            4'h7: cond_true = ~psr_q[N_BIT];
            4'h8: cond_true =  psr_q[F_BIT];
            4'h9: cond_true = ~psr_q[F_BIT];
            4'hA: cond_true = ~psr_q[L_BIT] & ~psr_q[Z_BIT];
            4'hB: cond_true =  psr_q[L_BIT] |  psr_q[Z_BIT];
            4'hC: cond_true = ~psr_q[N_BIT] & ~psr_q[Z_BIT];
            4'hD: cond_true =  psr_q[N_BIT] |  psr_q[Z_BIT];
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_alu_result_sink.sv
// Purpose: self-checking bench for alu_result_sink (condition table, handshake sequences, scoreboard).
// Latency: checks 1-cycle capture and no-bubble streaming.
// Backpressure: exercises stalled writeback, drain, and simultaneous drain+accept.
`timescale 1ns/1ps
module tb_alu_result_sink;
    localparam int WIDTH  = 16;
    localparam int NFLAGS = 5;
    localparam int CNT_W  = 5;   // small counter so saturation is reachable quickly

    typedef struct {
        logic [4:0] psr_v;
        logic [3:0] cc;
        logic       exp;
    } cond_vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              psr_wr_en;
    logic [NFLAGS-1:0] psr_wr_data;
    logic [NFLAGS-1:0] psr;
    logic [3:0]        cond;
    logic              cond_true;
    logic [CNT_W-1:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] sb[$];
    logic             full_m = 1'b0;
    cond_vec_t        vecs[$];

    always #5 clk = ~clk;

    alu_result_sink_if #(.WIDTH(WIDTH), .NFLAGS(NFLAGS)) bus ();

    alu_result_sink #(.WIDTH(WIDTH), .NFLAGS(NFLAGS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .psr_wr_en   (psr_wr_en),
        .psr_wr_data (psr_wr_data),
        .psr         (psr),
        .cond        (cond),
        .cond_true   (cond_true),
        .op_count    (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so decide here what the
    // coming rising edge must do. Expected data is queued when an op is issued
    // into a free slot and retired when the writeback side takes it.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            full_m = 1'b0;
        end else begin
            check("sb_wb_valid", bus.wb_valid, full_m);
            if (full_m && bus.wb_ready) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else                check("sb_wb_data", bus.wb_data, sb.pop_front());
            end
            if (bus.alu_valid && (!full_m || bus.wb_ready)) begin
                sb.push_back(bus.alu_c);
                full_m = 1'b1;
            end else if (bus.wb_ready) begin
                full_m = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0]      e0;
        logic [15:0]      e1;
        logic [WIDTH-1:0] v;

        // condition table: psr, cond, expected cond_true
        e0 = 16'h56AA;   // expected per cond 0..F with psr = 00000
        e1 = 16'h6955;   // expected per cond 0..F with psr = 11111
        for (int i = 0; i < 16; i++) vecs.push_back(cond_vec_t'{5'b00000, 4'(i), e0[i]});
        for (int i = 0; i < 16; i++) vecs.push_back(cond_vec_t'{5'b11111, 4'(i), e1[i]});
        vecs.push_back(cond_vec_t'{5'b00010, 4'h0, 1'b1});
        vecs.push_back(cond_vec_t'{5'b00010, 4'hA, 1'b0});
        vecs.push_back(cond_vec_t'{5'b00010, 4'hB, 1'b1});
        vecs.push_back(cond_vec_t'{5'b00010, 4'hC, 1'b0});
        vecs.push_back(cond_vec_t'{5'b00010, 4'hD, 1'b1});
        vecs.push_back(cond_vec_t'{5'b01000, 4'h4, 1'b1});
        vecs.push_back(cond_vec_t'{5'b01000, 4'hA, 1'b0});
        vecs.push_back(cond_vec_t'{5'b00001, 4'h6, 1'b1});
        vecs.push_back(cond_vec_t'{5'b00001, 4'hC, 1'b0});
        vecs.push_back(cond_vec_t'{5'b00001, 4'hD, 1'b1});
        vecs.push_back(cond_vec_t'{5'b10100, 4'h2, 1'b1});
        vecs.push_back(cond_vec_t'{5'b10100, 4'h8, 1'b1});
        vecs.push_back(cond_vec_t'{5'b10100, 4'h1, 1'b1});

        rst_n         = 1'b0;
        psr_wr_en     = 1'b0;
        psr_wr_data   = '0;
        cond          = 4'h0;
        bus.alu_valid = 1'b0;
        bus.alu_c     = '0;
        bus.alu_flags = '0;
        bus.flag_mask = '0;
        bus.wb_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_psr", psr, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_ready", bus.alu_ready, 1);
        rst_n = 1'b1;

        // condition codes against directly written PSR values
        foreach (vecs[i]) begin
            psr_wr_en   = 1'b1;
            psr_wr_data = vecs[i].psr_v;
            cond        = vecs[i].cc;
            step();
            psr_wr_en = 1'b0;
            #1;
            check($sformatf("psr_write_%b", vecs[i].psr_v), psr, vecs[i].psr_v);
            check($sformatf("cond_%h_psr_%b", vecs[i].cc, vecs[i].psr_v), cond_true, vecs[i].exp);
        end
        check("direct_write_no_count", op_count, 0);

        // basic accept
        bus.alu_valid = 1'b1;
        bus.alu_c     = 16'h00AB;
        bus.alu_flags = 5'b00010;
        bus.flag_mask = 5'b11111;
        bus.wb_ready  = 1'b1;
        cond          = 4'h0;
        step();
        bus.alu_valid = 1'b0;
        #1;
        check("t2_wb_data", bus.wb_data, 16'h00AB);
        check("t2_wb_valid", bus.wb_valid, 1);
        check("t2_psr", psr, 5'b00010);
        check("t2_cond_eq", cond_true, 1);
        check("t2_op_count", op_count, 1);
        step();
        check("drain_wb_valid", bus.wb_valid, 0);
        check("drain_wb_data_held", bus.wb_data, 16'h00AB);

        // backpressure
        bus.wb_ready  = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_c     = 16'h1111;
        bus.alu_flags = 5'b00001;
        step();
        check("t3_first_data", bus.wb_data, 16'h1111);
        check("t3_first_psr", psr, 5'b00001);
        bus.alu_c     = 16'h1234;
        bus.alu_flags = 5'b11111;
        #1;
        check("t3_alu_ready_low", bus.alu_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_data", bus.wb_data, 16'h1111);
            check("t3_hold_psr", psr, 5'b00001);
            check("t3_hold_count", op_count, 2);
            check("t3_hold_valid", bus.wb_valid, 1);
        end
        bus.wb_ready = 1'b1;
        #1;
        check("t3_alu_ready_high", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        check("t3_release_data", bus.wb_data, 16'h1234);
        check("t3_release_psr", psr, 5'b11111);
        check("t3_release_count", op_count, 3);

        // partial flag mask, accepted while the entry drains
        bus.alu_valid = 1'b1;
        bus.alu_c     = 16'h0044;
        bus.alu_flags = 5'b00000;
        bus.flag_mask = 5'b00011;
        step();
        bus.alu_valid = 1'b0;
        cond          = 4'hA;
        #1;
        check("t4_psr", psr, 5'b11100);
        check("t4_cond_lo", cond_true, 0);
        cond = 4'h6;
        #1;
        check("t4_cond_gt", cond_true, 0);
        cond = 4'hB;
        #1;
        check("t4_cond_hs", cond_true, 1);

        // direct PSR write beats the flag update but not the data capture
        psr_wr_en     = 1'b1;
        psr_wr_data   = 5'b10101;
        bus.alu_valid = 1'b1;
        bus.alu_c     = 16'h0055;
        bus.alu_flags = 5'b01010;
        bus.flag_mask = 5'b11111;
        step();
        psr_wr_en     = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        check("t5_psr", psr, 5'b10101);
        check("t5_wb_data", bus.wb_data, 16'h0055);
        check("t5_op_count", op_count, 5);

        // rejected op leaves psr, data and count alone
        bus.wb_ready  = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_c     = 16'h0066;
        bus.alu_flags = 5'b00000;
        step();
        check("reject_psr", psr, 5'b10101);
        check("reject_count", op_count, 5);
        check("reject_data", bus.wb_data, 16'h0055);

        // asynchronous reset mid-cycle with a full entry and a pending op
        bus.alu_c = 16'hDEAD;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_wb_valid", bus.wb_valid, 0);
        check("t1_psr", psr, 0);
        check("t1_op_count", op_count, 0);
        check("t1_wb_data", bus.wb_data, 0);
        step();
        check("t1_input_discarded", bus.wb_valid, 0);
        rst_n        = 1'b1;
        bus.wb_ready = 1'b1;

        // back-to-back stream straight out of reset
        for (int i = 0; i < 20; i++) begin
            v             = WIDTH'($urandom);
            bus.alu_valid = 1'b1;
            bus.alu_c     = v;
            bus.alu_flags = 5'($urandom);
            step();
            check("t6_no_bubble", bus.wb_valid, 1);
            check("t6_wb_data", bus.wb_data, v);
        end
        check("t6_op_count", op_count, 20);

        // counter saturation
        for (int i = 0; i < 11; i++) begin
            bus.alu_c = WIDTH'($urandom);
            step();
        end
        check("sat_reach", op_count, 31);
        for (int i = 0; i < 4; i++) begin
            bus.alu_c = WIDTH'($urandom);
            step();
        end
        check("sat_hold", op_count, 31);

        bus.alu_valid = 1'b0;
        step();
        check("final_wb_valid", bus.wb_valid, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
